ahb_handover_n: RTL

Parametrised AHB bus-handover stage for an N-master arbiter. It sits between the priority/grant logic and the bus, and owns bus ownership: it registers the granted master, the one-hot `hgrant`, the encoded `hmaster` and `hmastlock` at transfer boundaries. It also tracks the data-phase owner for the write-data mux, and holds ownership through locked sequences plus one tail cycle.

---
 rtl/ahb_handover_n.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ahb_handover_n.sv
// ahb_handover_n
//   AHB bus-handover stage for an N-master arbiter. Registers the granted
//   master (one-hot hgrant, encoded hmaster, hmastlock) at transfer
//   boundaries (hready & transfin), tracks the data-phase owner, and holds
//   ownership through locked sequences plus one hready-qualified tail cycle.
//
// Ports:
//   hclk, hresetn      : clock, asynchronous active-low reset
//   hready             : AHB ready; qualifies every state change
//   transfin           : current owner's transfer/burst finishes this cycle
//   grant[NUM_MST]     : grant from priority logic (one-hot or zero expected)
//   mastlock           : lock request of the master being granted
//   hgrant[NUM_MST]    : registered one-hot bus grant
//   hmaster[MST_W]     : registered address-phase owner
//   hmaster_data[MST_W]: data-phase owner (hmaster one hready cycle behind)
//   hmastlock          : registered lock of the current owner
//   handover           : one-cycle pulse after hmaster changed
//   grant_err          : one-cycle pulse after a multi-hot grant was sampled
module ahb_handover_n #(
    parameter int unsigned NUM_MST     = 5,
    parameter int unsigned MST_W       = 3,
    parameter int unsigned DEFAULT_MST = 0
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hready,
    input  logic               transfin,
    input  logic [NUM_MST-1:0] grant,
    input  logic               mastlock,
    output logic [NUM_MST-1:0] hgrant,
    output logic [MST_W-1:0]   hmaster,
    output logic [MST_W-1:0]   hmaster_data,
    output logic               hmastlock,
    output logic               handover,
    output logic               grant_err
);

    typedef enum logic [1:0] {
        OWNED,
        LOCKED,
        LOCK_TAIL
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_MST-1:0] hgrant_q, hgrant_d;
    logic [MST_W-1:0]   hmaster_q, hmaster_d;
    logic [MST_W-1:0]   hmaster_data_q, hmaster_data_d;
    logic               hmastlock_q, hmastlock_d;
    logic               handover_q, handover_d;
    logic               grant_err_q, grant_err_d;

    logic               boundary;
    logic [MST_W-1:0]   grant_idx;
    logic               grant_multi;

    assign boundary = hready & transfin;

    // Lowest set bit wins; zero grant falls back to the default master.
    always_comb begin
        grant_idx = MST_W'(DEFAULT_MST);
        for (int unsigned i = NUM_MST; i > 0; i--) begin
            if (grant[i-1]) begin
                grant_idx = MST_W'(i - 1);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if several were set.
    assign grant_multi = (grant & (grant - NUM_MST'(1))) != '0;

    always_comb begin
        state_d        = state_q;
        hgrant_d       = hgrant_q;
        hmaster_d      = hmaster_q;
        hmastlock_d    = hmastlock_q;
        grant_err_d    = 1'b0;
        hmaster_data_d = hready ? hmaster_q : hmaster_data_q;

        case (state_q)
            OWNED: begin
                if (boundary) begin
                    hmaster_d   = grant_idx;
                    hgrant_d    = NUM_MST'(1) << grant_idx;
                    hmastlock_d = mastlock;
                    grant_err_d = grant_multi;
                    if (mastlock) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Grant is ignored while locked; only the lock release matters.
                if (boundary && !mastlock) begin
                    hmastlock_d = 1'b0;
                    state_d     = LOCK_TAIL;
                end
            end
            LOCK_TAIL: begin
                // Owner is kept through the final locked data phase.
                if (hready) begin
                    state_d = OWNED;
                end
            end
            default: begin
                state_d = OWNED;
            end
        endcase

        handover_d = (hmaster_d != hmaster_q);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q        <= OWNED;
            hgrant_q       <= NUM_MST'(1) << DEFAULT_MST;
            hmaster_q      <= MST_W'(DEFAULT_MST);
            hmaster_data_q <= MST_W'(DEFAULT_MST);
            hmastlock_q    <= 1'b0;
            handover_q     <= 1'b0;
            grant_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            hgrant_q       <= hgrant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
            handover_q     <= handover_d;
            grant_err_q    <= grant_err_d;
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign hmastlock    = hmastlock_q;
    assign handover     = handover_q;
    assign grant_err    = grant_err_q;

endmodule
